// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 max-pool with optional ReLU over a raster-order pixel stream.
// One line of horizontal pair maxima is kept; each window's result goes out through a valid/ready register.
module maxpool2x2_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 24,
  parameter int IMG_H      = 24,
  parameter bit RELU_EN    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int LB_N  = IMG_W / 2;
  localparam int LB_AW = (LB_N > 1) ? $clog2(LB_N) : 1;

  logic [COL_W-1:0]             col_q, col_d;
  logic [ROW_W-1:0]             row_q, row_d;
  logic signed [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                         out_valid_q, out_valid_d;
  logic signed [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                         out_last_q, out_last_d;
  logic signed [DATA_WIDTH-1:0] linebuf_q [LB_N];

  logic                         accept, col_end, row_end, lb_we;
  logic [LB_AW-1:0]             lb_idx;
  logic signed [DATA_WIDTH-1:0] px, lb_rd, pair_max, win_max, pool_res;

  assign in_ready = ~clr & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;
  assign col_end  = (col_q == COL_W'(IMG_W - 1));
  assign row_end  = (row_q == ROW_W'(IMG_H - 1));
  assign lb_idx   = LB_AW'(col_q >> 1);
  assign px       = $signed(in_data);

  always_comb begin
    lb_rd    = linebuf_q[lb_idx];
    pair_max = (px > hold_q) ? px : hold_q;
    win_max  = (lb_rd > pair_max) ? lb_rd : pair_max;
    pool_res = (RELU_EN && win_max[DATA_WIDTH-1]) ? '0 : win_max;
  end

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    hold_d      = hold_q;
    lb_we       = 1'b0;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    // A completed beat frees the register; a same-edge load below overrides this.
    out_valid_d = out_valid_q & ~out_ready;
    if (clr) begin
      col_d       = '0;
      row_d       = '0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      out_data_d  = '0;
    end else if (accept) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      if (!col_q[0]) begin
        hold_d = px;
      end else if (!row_q[0]) begin
        lb_we = 1'b1;
      end else begin
        out_data_d  = pool_res;
        out_valid_d = 1'b1;
        out_last_d  = row_end & col_end;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      hold_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      hold_q      <= hold_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  // Every entry is written on an even row before the odd row reads it, so no reset is needed.
  always_ff @(posedge clk) begin
    if (lb_we) linebuf_q[lb_idx] <= pair_max;
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule
